muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width; only 32 supported.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port: CLK  input  1  rising-edge clock.
REQ-004 SHALL have port: RST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: MDStart  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port: MDOp  input  3  RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 SHALL have port: MDrs1  input  32  operand A, driven from register-file read port rs1.
REQ-008 SHALL have port: MDrs2  input  32  operand B, driven from register-file read port rs2.
REQ-009 SHALL have port: MDBusy  output  1  high while a request is in progress (CALC or DONE).
REQ-010 SHALL have port: MDDone  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: MDResult  output  32  result for register-file write-back.

Function
REQ-012 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-013 SHALL, in IDLE with MDStart=1 at a rising edge, latch MDOp, MDrs1 and MDrs2 and leave IDLE; MDStart in any other state SHALL be ignored.
REQ-014 SHALL run signed operations on magnitudes and apply the result sign after the last iteration: MULHSU treats A as signed and B as unsigned; quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
REQ-015 SHALL run multiplies as a 32-iteration shift-add on a 64-bit product; MUL returns bits [31:0], and MULH/MULHSU/MULHU return bits [63:32].
REQ-016 SHALL run divides as a 32-iteration restoring divider, one quotient bit per cycle.
REQ-017 SHALL stay in CALC for exactly 32 cycles, enter DONE, and assert MDDone for exactly one cycle, on the 33rd edge after the accept edge.
REQ-018 SHALL handle divide-by-zero by skipping CALC and entering DONE on the accept edge: DIV/DIVU return 0xFFFFFFFF, and REM/REMU return MDrs1.
REQ-019 SHALL handle signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF) by skipping CALC: DIV returns 0x80000000 and REM returns 0.
REQ-020 SHALL hold MDResult stable from the MDDone cycle until the next accepted request; MDResult is don't-care while in CALC.
REQ-021 SHALL accept a new MDStart in the cycle after DONE (back-to-back issue), with no dead cycle beyond DONE.
REQ-022 SHALL NOT let input changes after the accept edge affect the result.

Reset
REQ-023 SHALL, while RST_N=0, force state IDLE, MDBusy=0, MDDone=0, MDResult=0, and clear the iteration counter and all operand registers.
REQ-024 SHALL treat reset asserted mid-operation as an abort: no MDDone pulse is produced, and operation resumes in IDLE.

Configuration
REQ-025 SHALL, with macro MULDIV_FAST_MUL_EN defined, compute all multiply ops with a single-cycle 64-bit multiplier, skipping CALC so MDDone occurs on the first edge after accept; divide timing is unchanged.
REQ-026 SHALL, without MULDIV_FAST_MUL_EN, use the iterative multiplier per REQ-015/REQ-017 and contain no hardware multiplier.

Structure
REQ-027 SHALL take from package muldiv_pkg: the op enum (funct3 codes), the FSM state enum, ITER_COUNT=32, DIV0_QUOTIENT=32'hFFFFFFFF and INT_MIN=32'h80000000.
REQ-028 SHALL place the iterative restoring divider (magnitude in, quotient/remainder out, with start/done handshake) in sub-module muldiv_divider; the multiplier, sign logic and FSM stay in muldiv_unit.

Verification
REQ-029 SHALL cover: MUL 7 x -3 -> MDResult=0xFFFFFFEB, MDDone 33 cycles after accept (1 cycle with MULDIV_FAST_MUL_EN).
REQ-030 SHALL cover: MULH/MULHSU/MULHU with A=0xFFFFFFFF, B=0xFFFFFFFF -> 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE.
REQ-031 SHALL cover: DIV -20/6 -> 0xFFFFFFFD; REM -20/6 -> 0xFFFFFFFE; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
REQ-032 SHALL cover: DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with MDDone one cycle after accept; DIV 0x80000000/-1 -> 0x80000000.
REQ-033 SHALL cover: MDStart pulsed and operands changed during CALC -> ignored; result matches the originally latched operands; back-to-back request accepted the cycle after DONE.
REQ-034 SHALL cover: RST_N low at CALC cycle 10 -> outputs zero, no MDDone; a new DIVU 100/7 after reset -> 14.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types, constants and result-shaping helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int          ITER_COUNT    = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic is_div_op(md_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic a_is_signed(md_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_is_signed(md_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  // Datapaths work on magnitudes; the sign is applied once here at the end.
  function automatic logic [31:0] mul_select(md_op_e op, logic [63:0] mag, logic neg);
    logic [63:0] p;
    p = neg ? -mag : mag;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] div_select(md_op_e op, logic [31:0] quo, logic [31:0] rem,
                                             logic neg);
    logic [31:0] v;
    v = (op inside {OP_DIV, OP_DIVU}) ? quo : rem;
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            MDStart;
  logic [2:0]      MDOp;
  logic [XLEN-1:0] MDrs1;
  logic [XLEN-1:0] MDrs2;
  logic            MDBusy;
  logic            MDDone;
  logic [XLEN-1:0] MDResult;

  modport master (output MDStart, MDOp, MDrs1, MDrs2, input MDBusy, MDDone, MDResult);
  modport slave  (input MDStart, MDOp, MDrs1, MDrs2, output MDBusy, MDDone, MDResult);
endinterface

// File: rtl/muldiv_divider.sv
// Unsigned 32-iteration restoring divider. done_o flags the cycle whose step yields the final
// quotient/remainder, which quotient_o/remainder_o carry in that same cycle.
module muldiv_divider
  import muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic        busy_q, busy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] trial;
  logic [31:0] step_quo, step_rem;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    // A borrow out of the trial subtraction means the divisor did not fit: restore.
    trial    = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    step_rem = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
    step_quo = {quo_q[30:0], ~trial[32]};
    done_o   = busy_q && (cnt_q == 5'(ITER_COUNT - 1));
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
    end else if (busy_q) begin
      quo_d = step_quo;
      rem_d = step_rem;
      cnt_d = cnt_q + 5'd1;
      if (done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  assign quotient_o  = step_quo;
  assign remainder_o = step_rem;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiplier, restoring divider, sign fix-up.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle one.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic     CLK,
  input logic     RST_N,
  muldiv_if.slave md
);

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic              neg_q, neg_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   result_q, result_d;

  md_op_e            req_op;
  logic              sign_a, sign_b, req_neg, req_div0, req_ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic              div_start, div_done, last_iter;
  logic [XLEN-1:0]   div_quo, div_rem;

  assign req_op   = md_op_e'(md.MDOp);
  assign sign_a   = a_is_signed(req_op) & md.MDrs1[XLEN-1];
  assign sign_b   = b_is_signed(req_op) & md.MDrs2[XLEN-1];
  assign mag_a    = sign_a ? -md.MDrs1 : md.MDrs1;
  assign mag_b    = sign_b ? -md.MDrs2 : md.MDrs2;
  assign req_neg  = (req_op == OP_REM) ? sign_a : (sign_a ^ sign_b);
  assign req_div0 = (md.MDrs2 == '0);
  assign req_ovf  = (req_op inside {OP_DIV, OP_REM}) && (md.MDrs1 == INT_MIN) && (md.MDrs2 == '1);

  // Shift-add step: conditionally add the multiplicand into the high half, then shift right.
  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : {XLEN{1'b0}})};
  assign mul_step  = {mul_sum, prod_q[XLEN-1:1]};
  assign last_iter = is_div_op(op_q) ? div_done : (cnt_q == 5'(ITER_COUNT - 1));

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    result_d  = result_q;
    div_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (md.MDStart) begin
          op_d    = req_op;
          neg_d   = req_neg;
          cnt_d   = '0;
          mcand_d = mag_a;
          prod_d  = {{XLEN{1'b0}}, mag_b};
          if (is_div_op(req_op)) begin
            if (req_div0) begin
              result_d = (req_op inside {OP_DIV, OP_DIVU}) ? DIV0_QUOTIENT : md.MDrs1;
              state_d  = ST_DONE;
            end else if (req_ovf) begin
              result_d = (req_op == OP_DIV) ? INT_MIN : '0;
              state_d  = ST_DONE;
            end else begin
              div_start = 1'b1;
              state_d   = ST_CALC;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            result_d = mul_select(req_op, fast_prod, req_neg);
            state_d  = ST_DONE;
`else
            state_d  = ST_CALC;
`endif
          end
        end
      end
      ST_CALC: begin
        cnt_d  = cnt_q + 5'd1;
        prod_d = mul_step;
        if (last_iter) begin
          result_d = is_div_op(op_q) ? div_select(op_q, div_quo, div_rem, neg_q)
                                     : mul_select(op_q, mul_step, neg_q);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      result_q <= result_d;
    end
  end

  muldiv_divider u_divider (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .start_i    (div_start),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  assign md.MDBusy   = (state_q != ST_IDLE);
  assign md.MDDone   = (state_q == ST_DONE);
  assign md.MDResult = result_q;

endmodule
